// File: rtl/pwm_regs_pkg.sv
// rtl/pwm_regs_pkg.sv - register offsets and field positions for the PWM register bank
package pwm_regs_pkg;

    localparam logic [3:0] OFS_PERIOD_LO = 4'h0;
    localparam logic [3:0] OFS_PERIOD_HI = 4'h1;
    localparam logic [3:0] OFS_EN        = 4'h2;
    localparam logic [3:0] OFS_CMP1_LO   = 4'h3;
    localparam logic [3:0] OFS_CMP1_HI   = 4'h4;
    localparam logic [3:0] OFS_CMP2_LO   = 4'h5;
    localparam logic [3:0] OFS_CMP2_HI   = 4'h6;
    localparam logic [3:0] OFS_CNT_RST   = 4'h7;
    localparam logic [3:0] OFS_CNT_LO    = 4'h8;
    localparam logic [3:0] OFS_CNT_HI    = 4'h9;
    localparam logic [3:0] OFS_PRESCALE  = 4'hA;
    localparam logic [3:0] OFS_UPDOWN    = 4'hB;
    localparam logic [3:0] OFS_PWM_EN    = 4'hC;
    localparam logic [3:0] OFS_FUNCTIONS = 4'hD;
    localparam logic [3:0] OFS_STATUS    = 4'hE;
    localparam logic [3:0] OFS_CTRL      = 4'hF;

    localparam int EN_BIT      = 0;
    localparam int CR_TRIG_BIT = 0;
    localparam int UND_BIT     = 0;
    localparam int PWM_EN_BIT  = 0;
    localparam int PENDING_BIT = 0;
    localparam int FORCE_BIT   = 0;

    localparam int FUNC_W = 2;

    // count_reset stays high this many cycles after a trigger
    localparam logic [1:0] CR_PULSE_LEN = 2'd2;

endpackage

// File: rtl/pwm_regs_if.sv
// rtl/pwm_regs_if.sv - decoder-side register bus for the PWM register bank
interface pwm_regs_if;
    logic       read;
    logic       write;
    logic [7:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;

    modport master (output read, output write, output addr, output data_write, input data_read);
    modport slave  (input read, input write, input addr, input data_write, output data_read);
endinterface

// File: rtl/pwm_regs_ch.sv
// rtl/pwm_regs_ch.sv - one channel's registers, shadow/pending logic and count_reset pulse (PWM_REGS_SHADOW_EN)
module pwm_regs_ch
    import pwm_regs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr,
    input  logic [3:0]        i_ofs,
    input  logic [7:0]        i_wdata,
    input  logic              i_update_evt,
    input  logic [CNT_W-1:0]  i_cnt,
    output logic [7:0]        o_rdata,
    output logic [CNT_W-1:0]  o_period,
    output logic [CNT_W-1:0]  o_compare1,
    output logic [CNT_W-1:0]  o_compare2,
    output logic              o_en,
    output logic              o_count_reset,
    output logic              o_upnotdown,
    output logic              o_pwm_en,
    output logic [7:0]        o_prescale,
    output logic [FUNC_W-1:0] o_functions
);

    function automatic logic [CNT_W-1:0] f_wr_byte(input logic [CNT_W-1:0] v,
                                                   input logic hi,
                                                   input logic [7:0] d);
        logic [CNT_W-1:0] r;
        r = v;
        if (hi) r[CNT_W-1:8] = d[CNT_W-9:0];
        else    r[7:0]       = d;
        return r;
    endfunction

    logic [CNT_W-1:0]  r_period, r_cmp1, r_cmp2;
    logic              r_en, r_upnotdown, r_pwm_en;
    logic [7:0]        r_prescale;
    logic [FUNC_W-1:0] r_functions;
    logic [1:0]        r_cr_cnt;

    logic [CNT_W-1:0]  w_rb_period, w_rb_cmp1, w_rb_cmp2;
    logic              w_pending;

`ifdef PWM_REGS_SHADOW_EN
    logic [CNT_W-1:0] r_sh_period, r_sh_cmp1, r_sh_cmp2;
    logic             r_pending;
    logic             w_sh_wr, w_force, w_load;

    assign w_sh_wr = i_wr && (i_ofs <= OFS_CMP2_HI) && (i_ofs != OFS_EN);
    assign w_force = i_wr && (i_ofs == OFS_CTRL) && i_wdata[FORCE_BIT];
    assign w_load  = w_force || (r_pending && (i_update_evt || !r_en));

    // shadow capture and shadow->active load; a same-cycle write lands after the load and re-arms pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_period <= '0;
            r_sh_cmp1   <= '0;
            r_sh_cmp2   <= '0;
            r_period    <= '0;
            r_cmp1      <= '0;
            r_cmp2      <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_load) begin
                r_period  <= r_sh_period;
                r_cmp1    <= r_sh_cmp1;
                r_cmp2    <= r_sh_cmp2;
                r_pending <= 1'b0;
            end
            if (w_sh_wr) begin
                r_pending <= 1'b1;
                case (i_ofs)
                    OFS_PERIOD_LO: r_sh_period <= f_wr_byte(r_sh_period, 1'b0, i_wdata);
                    OFS_PERIOD_HI: r_sh_period <= f_wr_byte(r_sh_period, 1'b1, i_wdata);
                    OFS_CMP1_LO:   r_sh_cmp1   <= f_wr_byte(r_sh_cmp1,   1'b0, i_wdata);
                    OFS_CMP1_HI:   r_sh_cmp1   <= f_wr_byte(r_sh_cmp1,   1'b1, i_wdata);
                    OFS_CMP2_LO:   r_sh_cmp2   <= f_wr_byte(r_sh_cmp2,   1'b0, i_wdata);
                    OFS_CMP2_HI:   r_sh_cmp2   <= f_wr_byte(r_sh_cmp2,   1'b1, i_wdata);
                    default: ;
                endcase
            end
        end
    end

    assign w_rb_period = r_sh_period;
    assign w_rb_cmp1   = r_sh_cmp1;
    assign w_rb_cmp2   = r_sh_cmp2;
    assign w_pending   = r_pending;
`else
    logic w_unused_evt;
    assign w_unused_evt = i_update_evt;

    // without double buffering, period/compare bytes are written straight to the active registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
            r_cmp1   <= '0;
            r_cmp2   <= '0;
        end else if (i_wr) begin
            case (i_ofs)
                OFS_PERIOD_LO: r_period <= f_wr_byte(r_period, 1'b0, i_wdata);
                OFS_PERIOD_HI: r_period <= f_wr_byte(r_period, 1'b1, i_wdata);
                OFS_CMP1_LO:   r_cmp1   <= f_wr_byte(r_cmp1,   1'b0, i_wdata);
                OFS_CMP1_HI:   r_cmp1   <= f_wr_byte(r_cmp1,   1'b1, i_wdata);
                OFS_CMP2_LO:   r_cmp2   <= f_wr_byte(r_cmp2,   1'b0, i_wdata);
                OFS_CMP2_HI:   r_cmp2   <= f_wr_byte(r_cmp2,   1'b1, i_wdata);
                default: ;
            endcase
        end
    end

    assign w_rb_period = r_period;
    assign w_rb_cmp1   = r_cmp1;
    assign w_rb_cmp2   = r_cmp2;
    assign w_pending   = 1'b0;
`endif

    // directly written control fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en        <= 1'b0;
            r_upnotdown <= 1'b0;
            r_pwm_en    <= 1'b0;
            r_prescale  <= '0;
            r_functions <= '0;
        end else if (i_wr) begin
            case (i_ofs)
                OFS_EN:        r_en        <= i_wdata[EN_BIT];
                OFS_PRESCALE:  r_prescale  <= i_wdata;
                OFS_UPDOWN:    r_upnotdown <= i_wdata[UND_BIT];
                OFS_PWM_EN:    r_pwm_en    <= i_wdata[PWM_EN_BIT];
                OFS_FUNCTIONS: r_functions <= i_wdata[FUNC_W-1:0];
                default: ;
            endcase
        end
    end

    // count_reset pulse: a trigger (re)loads the down-counter, output is high while it is nonzero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cr_cnt <= '0;
        end else if (i_wr && (i_ofs == OFS_CNT_RST) && i_wdata[CR_TRIG_BIT]) begin
            r_cr_cnt <= CR_PULSE_LEN;
        end else if (r_cr_cnt != '0) begin
            r_cr_cnt <= r_cr_cnt - 2'd1;
        end
    end

    // readback value for the currently addressed offset
    always_comb begin
        o_rdata = '0;
        case (i_ofs)
            OFS_PERIOD_LO: o_rdata = w_rb_period[7:0];
            OFS_PERIOD_HI: o_rdata = 8'(w_rb_period[CNT_W-1:8]);
            OFS_EN:        o_rdata[EN_BIT] = r_en;
            OFS_CMP1_LO:   o_rdata = w_rb_cmp1[7:0];
            OFS_CMP1_HI:   o_rdata = 8'(w_rb_cmp1[CNT_W-1:8]);
            OFS_CMP2_LO:   o_rdata = w_rb_cmp2[7:0];
            OFS_CMP2_HI:   o_rdata = 8'(w_rb_cmp2[CNT_W-1:8]);
            OFS_CNT_LO:    o_rdata = i_cnt[7:0];
            OFS_CNT_HI:    o_rdata = 8'(i_cnt[CNT_W-1:8]);
            OFS_PRESCALE:  o_rdata = r_prescale;
            OFS_UPDOWN:    o_rdata[UND_BIT] = r_upnotdown;
            OFS_PWM_EN:    o_rdata[PWM_EN_BIT] = r_pwm_en;
            OFS_FUNCTIONS: o_rdata[FUNC_W-1:0] = r_functions;
            OFS_STATUS:    o_rdata[PENDING_BIT] = w_pending;
            default:       o_rdata = '0;
        endcase
    end

    assign o_period      = r_period;
    assign o_compare1    = r_cmp1;
    assign o_compare2    = r_cmp2;
    assign o_en          = r_en;
    assign o_count_reset = (r_cr_cnt != '0);
    assign o_upnotdown   = r_upnotdown;
    assign o_pwm_en      = r_pwm_en;
    assign o_prescale    = r_prescale;
    assign o_functions   = r_functions;

endmodule

// File: rtl/pwm_regs_mc.sv
// rtl/pwm_regs_mc.sv - multi-channel PWM register bank: address decode and registered read mux (PWM_REGS_SHADOW_EN)
module pwm_regs_mc
    import pwm_regs_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pwm_regs_if.slave                bus,
    input  logic [NUM_CH*CNT_W-1:0]  counter_val,
    input  logic [NUM_CH-1:0]        update_evt,
    output logic [NUM_CH*CNT_W-1:0]  period,
    output logic [NUM_CH*CNT_W-1:0]  compare1,
    output logic [NUM_CH*CNT_W-1:0]  compare2,
    output logic [NUM_CH-1:0]        en,
    output logic [NUM_CH-1:0]        count_reset,
    output logic [NUM_CH-1:0]        upnotdown,
    output logic [NUM_CH-1:0]        pwm_en,
    output logic [NUM_CH*8-1:0]      prescale,
    output logic [NUM_CH*FUNC_W-1:0] functions
);

    logic [NUM_CH-1:0] w_sel;
    logic [7:0]        w_ch_rdata [NUM_CH];
    logic [7:0]        w_rd_mux;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_sel[c] = (bus.addr[7:4] == 4'(c));

        pwm_regs_ch #(.CNT_W(CNT_W)) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_wr          (bus.write && w_sel[c]),
            .i_ofs         (bus.addr[3:0]),
            .i_wdata       (bus.data_write),
            .i_update_evt  (update_evt[c]),
            .i_cnt         (counter_val[c*CNT_W +: CNT_W]),
            .o_rdata       (w_ch_rdata[c]),
            .o_period      (period[c*CNT_W +: CNT_W]),
            .o_compare1    (compare1[c*CNT_W +: CNT_W]),
            .o_compare2    (compare2[c*CNT_W +: CNT_W]),
            .o_en          (en[c]),
            .o_count_reset (count_reset[c]),
            .o_upnotdown   (upnotdown[c]),
            .o_pwm_en      (pwm_en[c]),
            .o_prescale    (prescale[c*8 +: 8]),
            .o_functions   (functions[c*FUNC_W +: FUNC_W])
        );
    end

    // select the addressed channel's readback; unpopulated channels read 0
    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel[c]) w_rd_mux = w_ch_rdata[c];
        end
    end

    // registered read data, held between read strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_read <= '0;
        end else if (bus.read) begin
            bus.data_read <= w_rd_mux;
        end
    end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// tb/tb_pwm_regs_mc.sv - directed self-checking bench for pwm_regs_mc (PWM_REGS_SHADOW_EN aware)
module tb_pwm_regs_mc;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
`ifdef PWM_REGS_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [NUM_CH*CNT_W-1:0] counter_val;
    logic [NUM_CH-1:0]       update_evt;
    logic [NUM_CH*CNT_W-1:0] period, compare1, compare2;
    logic [NUM_CH-1:0]       en, count_reset, upnotdown, pwm_en;
    logic [NUM_CH*8-1:0]     prescale;
    logic [NUM_CH*2-1:0]     functions;

    int n_checks = 0;
    int n_errors = 0;

    pwm_regs_if bus ();

    pwm_regs_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .counter_val (counter_val),
        .update_evt  (update_evt),
        .period      (period),
        .compare1    (compare1),
        .compare2    (compare2),
        .en          (en),
        .count_reset (count_reset),
        .upnotdown   (upnotdown),
        .pwm_en      (pwm_en),
        .prescale    (prescale),
        .functions   (functions)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // caller sits at a negedge; strobe is sampled at the following posedge
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus.write = 1'b1; bus.addr = a; bus.data_write = d;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic bus_write_evt(input logic [7:0] a, input logic [7:0] d, input logic [NUM_CH-1:0] ev);
        bus.write = 1'b1; bus.addr = a; bus.data_write = d; update_evt = ev;
        @(negedge clk);
        bus.write = 1'b0; update_evt = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        bus.read = 1'b1; bus.addr = a;
        @(negedge clk);
        bus.read = 1'b0;
        d = bus.data_read;
    endtask

    logic [7:0] rd;

    initial begin
        rst_n = 1'b0;
        bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.data_write = '0;
        counter_val = '0; update_evt = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_period",   period,   64'h0);
        check("rst_compare1", compare1, 64'h0);
        check("rst_compare2", compare2, 64'h0);
        check("rst_ctrl",     {en, count_reset, upnotdown, pwm_en}, 64'h0);
        check("rst_pre_func", {prescale, functions}, 64'h0);
        check("rst_rdata",    bus.data_read, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(8'h00, rd);
        check("rd_ch0_period_lo", rd, 64'h00);

        // ch1 with en=0: shadow bytes propagate without an event
        bus_write(8'h10, 8'h34);
        bus_write(8'h11, 8'h12);
        @(negedge clk);
        check("ch1_period", period[31:16], 64'h1234);
        bus_read(8'h1E, rd);
        check("ch1_status", rd, 64'h00);

        // ch0 with en=1: compare1 waits for update_evt
        bus_write(8'h02, 8'h01);
        check("ch0_en", en, 64'h1);
        bus_write(8'h03, 8'h80);
        bus_write(8'h04, 8'h00);
        check("ch0_cmp1_before_evt", compare1[15:0], SH ? 64'h0000 : 64'h0080);
        bus_read(8'h0E, rd);
        check("ch0_status_pending", rd, SH ? 64'h01 : 64'h00);
        bus_read(8'h03, rd);
        check("ch0_cmp1_lo_readback", rd, 64'h80);
        update_evt = 4'b0001;
        @(negedge clk);
        update_evt = '0;
        check("ch0_cmp1_after_evt", compare1[15:0], 64'h0080);
        bus_read(8'h0E, rd);
        check("ch0_status_clear", rd, 64'h00);
        repeat (2) @(negedge clk);
        check("rdata_hold", bus.data_read, 64'h00);

        // count_reset pulse: exactly 2 cycles
        bus_write(8'h27, 8'h01);
        check("cr_cyc1", count_reset, 64'b0100);
        @(negedge clk);
        check("cr_cyc2", count_reset, 64'b0100);
        @(negedge clk);
        check("cr_cyc3_low", count_reset, 64'b0000);
        bus_read(8'h27, rd);
        check("cr_read_zero", rd, 64'h00);
        // re-trigger at the start of the second high cycle: 3 high cycles in total
        bus_write(8'h27, 8'h01);
        check("cr_rt_cyc1", count_reset[2], 64'h1);
        bus_write(8'h27, 8'h01);
        check("cr_rt_cyc2", count_reset[2], 64'h1);
        @(negedge clk);
        check("cr_rt_cyc3", count_reset[2], 64'h1);
        @(negedge clk);
        check("cr_rt_cyc4_low", count_reset[2], 64'h0);

        // counter_val readback, read-only
        counter_val[63:48] = 16'hBEEF;
        bus_read(8'h38, rd);
        check("cnt_lo", rd, 64'hEF);
        bus_read(8'h39, rd);
        check("cnt_hi", rd, 64'hBE);
        bus_write(8'h38, 8'h55);
        check("ro_write_period",   period,   64'h0000_0000_1234_0000);
        check("ro_write_compare1", compare1, 64'h0000_0000_0000_0080);
        check("ro_write_misc",     {compare2, en, prescale, functions, upnotdown, pwm_en}, {64'h0, 4'b0001, 32'h0, 8'h0, 4'h0, 4'h0});
        bus_read(8'h38, rd);
        check("cnt_lo_again", rd, 64'hEF);

        // out-of-range channel
        bus_write(8'h50, 8'hAB);
        bus_write(8'h5A, 8'hFF);
        check("oor_period",   period,   64'h0000_0000_1234_0000);
        check("oor_prescale", prescale, 64'h0);
        bus_read(8'h50, rd);
        check("oor_read", rd, 64'h00);

        // direct fields and narrow-register readback
        bus_write(8'h3A, 8'hA5);
        check("prescale_ch3", prescale[31:24], 64'hA5);
        bus_write(8'h3D, 8'hFF);
        check("functions_ch3", functions, 64'b11_00_00_00);
        bus_read(8'h3D, rd);
        check("functions_rd", rd, 64'h03);
        bus_write(8'h1B, 8'hFF);
        bus_write(8'h1C, 8'h01);
        check("und_pwm_en", {upnotdown, pwm_en}, {4'b0010, 4'b0010});

        // shadow write coinciding with update_evt
        bus_write(8'h05, 8'h22);
        bus_write_evt(8'h03, 8'h11, 4'b0001);
        check("same_cyc_cmp1", compare1[15:0], SH ? 64'h0080 : 64'h0011);
        check("same_cyc_cmp2", compare2[15:0], 64'h0022);
        bus_read(8'h0E, rd);
        check("same_cyc_pending", rd, SH ? 64'h01 : 64'h00);
        update_evt = 4'b0001;
        @(negedge clk);
        update_evt = '0;
        check("next_evt_cmp1", compare1[15:0], 64'h0011);

        // force load through control register
        bus_write(8'h06, 8'h01);
        check("cmp2_before_force", compare2[15:0], SH ? 64'h0022 : 64'h0122);
        bus_write(8'h0F, 8'h01);
        check("cmp2_after_force", compare2[15:0], 64'h0122);
        bus_read(8'h0E, rd);
        check("force_status", rd, 64'h00);

        // asynchronous reset in the middle of a count_reset pulse
        bus_write(8'h17, 8'h01);
        check("cr_ch1_high", count_reset, 64'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("cr_async_clear", count_reset, 64'h0);
        check("async_clear_cmp", {period, compare1}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pwm_regs_mc.md
# pwm_regs_mc

Multi-channel, parametrised register bank for the PWM generator. It sits between the SPI/bus decoder and NUM_CH counter/PWM channel pairs. Each channel has its own programming registers. Period and compare values are double-buffered: decoder writes land in shadow registers, and the shadow values move to the channel outputs only at that channel's counter update event, so the PWM waveform never glitches mid-period.

## Interface
Parameters:
- NUM_CH, 4: number of channels, 1..16.
- CNT_W, 16: counter/compare width, 9..16.

Ports:
- clk  in  1: peripheral clock.
- rst_n  in  1: reset, asynchronous, active-low.
- read  in  1: one-cycle read strobe from the decoder.
- write  in  1: one-cycle write strobe from the decoder.
- addr  in  8: address. addr[7:4] selects the channel; addr[3:0] selects the register offset.
- data_write  in  8: write data.
- data_read  out  8: registered read data.
- counter_val  in  NUM_CH*CNT_W: live counter values; channel c uses bits [c*CNT_W +: CNT_W].
- update_evt  in  NUM_CH: one-cycle pulse per channel at counter overflow/underflow.
- period, compare1, compare2  out  NUM_CH*CNT_W each: active values.
- en, count_reset, upnotdown, pwm_en  out  NUM_CH each.
- prescale  out  NUM_CH*8.
- functions  out  NUM_CH*2.

## Operation
Per-channel register offsets (R/W unless marked):
- 0x0/0x1: period lo/hi (shadow).
- 0x2: en[0].
- 0x3/0x4: compare1 lo/hi (shadow).
- 0x5/0x6: compare2 lo/hi (shadow).
- 0x7: count_reset, write-only. Writing bit0=1 triggers the pulse. Reads return 0.
- 0x8/0x9: counter_val lo/hi, read-only. Writes are ignored.
- 0xA: prescale[7:0].
- 0xB: upnotdown[0].
- 0xC: pwm_en[0].
- 0xD: functions[1:0].
- 0xE: status, read-only. bit0 = pending.
- 0xF: control, write-only. Writing bit0=1 forces a shadow→active load.

Hi-byte rules: a hi byte holds bits CNT_W-1:8. Unused bits read 0 and ignore writes. Unused bits of narrow registers also read 0.

Shadow/active rules:
- Any write to offsets 0x0–0x6 (shadow bytes) sets pending[c].
- The shadow→active load copies all three shadow values together. It happens on the cycle after any of these, when pending[c]=1:
  - update_evt[c]=1, or
  - en[c]=0.
- A force write to 0xF loads unconditionally; pending is not required.
- A load clears pending.

count_reset pulse:
- Asserted the cycle after the trigger write and held high for exactly 2 cycles.
- A re-trigger during the pulse restarts the 2-cycle count.

Channel select:
- A channel index ≥ NUM_CH ignores writes.
- Reads of such a channel return 0x00.

## Timing
- Reset: every output, shadow register, pending bit and data_read is 0.
- Write: the target register updates at the strobe's clock edge and is visible on the outputs next cycle. Non-shadowed fields (en, prescale, upnotdown, pwm_en, functions) are written directly.
- Read: data_read updates at the strobe's edge. Latency is 1 cycle. data_read holds its value when read=0.
- Read and write to the same address in the same cycle: the read returns the old value.
- Shadow write and update_evt in the same cycle:
  - The active registers load the pre-write shadow values.
  - pending ends at 1.
  - The new byte waits for the next event.
- Force write to 0xF together with update_evt: a single load occurs.
- A reset in the middle of a count_reset pulse clears it immediately.

## Configuration
- PWM_REGS_SHADOW_EN defined: double buffering as described above.
- Not defined:
  - Writes to 0x0–0x6 go straight to the active registers.
  - update_evt is ignored.
  - Status reads 0.
  - 0xF writes are no-ops.

## Structure
- Package pwm_regs_pkg holds the register offset localparams (OFS_PERIOD_LO … OFS_CTRL), the channel-field bit positions, and a `functions` width constant.
- Sub-module pwm_regs_ch holds one channel's registers, shadow and pending logic, and count_reset pulse counter. It is instantiated NUM_CH times.
- The top level does address decode and the registered read mux.

## Test plan
- Reset → all outputs 0. A read of ch0 0x0 returns 0x00.
- With en[1]=0, write ch1 0x0=0x34 and 0x1=0x12 → period ch1 = 0x1234 one cycle later. Pending reads 0.
- With en[0]=1, write compare1=0x0080 → active value unchanged and status=1. Pulse update_evt[0] → compare1=0x0080 next cycle, status=0.
- Write ch2 0x7=0x01 → count_reset[2] high for exactly 2 cycles. A re-trigger on the second high cycle → high for 3 cycles total.
- Drive counter_val ch3=0xBEEF → reads of 0x38/0x39 return 0xEF/0xBE. Writes to 0x38 leave all state unchanged.
- With NUM_CH=4, write to addr 0x50 → no change. A read of 0x50 → 0x00.
- A shadow write in the same cycle as update_evt → active takes the old shadow value, pending=1. Repeat with PWM_REGS_SHADOW_EN undefined → the write is visible immediately.
